// File: rtl/lod_norm_arbiter.sv
// Shared leading-one normalizer for the trig datapath.
// A round-robin arbiter picks one of N requesters; stage 1 captures the value
// and finds its leading-one position, stage 2 left-shifts it to the MSB and
// reports the shift amount together with the originating requester ID.
module lod_norm_arbiter #(
    parameter int W  = 10,
    parameter int N  = 2,
    parameter int SW = 4,
    parameter int IW = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [N*W-1:0]  req_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_shift,
    output logic            out_zero,
    output logic [IW-1:0]   out_id
);

    // Position of the leading one, counted from 1; 0 means the value is zero.
    function automatic logic [SW-1:0] leadPos(input logic [W-1:0] v);
        logic [SW-1:0] pos;
        pos = '0;
        for (int k = 0; k < W; k++) begin
            if (v[k]) pos = SW'(k + 1);
        end
        return pos;
    endfunction

    logic [IW-1:0] rrPtr;

    logic          vldP1;
    logic [W-1:0]  dataP1;
    logic [IW-1:0] idP1;
    logic [SW-1:0] posP1;

    logic          vldP2;
    logic [W-1:0]  dataP2;
    logic [SW-1:0] shiftP2;
    logic          zeroP2;
    logic [IW-1:0] idP2;

    logic          adv1;
    logic          adv2;
    logic          grantHit;
    logic [IW-1:0] grantId;
    logic [W-1:0]  selData;
    logic [SW-1:0] shiftP1;

    assign adv2    = !vldP2 || out_ready;
    assign adv1    = !vldP1 || adv2;
    assign shiftP1 = SW'(W) - posP1;

    // Round-robin grant: first valid requester scanning upward from rrPtr.
    always_comb begin
        grantHit  = 1'b0;
        grantId   = '0;
        selData   = '0;
        req_ready = '0;
        if (adv1 && reset) begin
            for (int off = 0; off < N; off++) begin
                for (int i = 0; i < N; i++) begin
                    if (!grantHit && (i == (int'(rrPtr) + off) % N) && req_valid[i]) begin
                        grantHit     = 1'b1;
                        grantId      = IW'(i);
                        selData      = req_data[i*W +: W];
                        req_ready[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Advance the round-robin pointer past the requester just served.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rrPtr <= '0;
        end else if (grantHit) begin
            rrPtr <= (int'(grantId) == N - 1) ? '0 : grantId + 1'b1;
        end
    end

    // Stage 1: capture the granted value and its leading-one position.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vldP1  <= 1'b0;
            dataP1 <= '0;
            idP1   <= '0;
            posP1  <= '0;
        end else if (adv1) begin
            vldP1 <= grantHit;
            if (grantHit) begin
                dataP1 <= selData;
                idP1   <= grantId;
                posP1  <= leadPos(selData);
            end
        end
    end

    // Stage 2: shift the leading one up to the MSB; a zero value shifts out to 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vldP2   <= 1'b0;
            dataP2  <= '0;
            shiftP2 <= '0;
            zeroP2  <= 1'b0;
            idP2    <= '0;
        end else if (adv2) begin
            vldP2 <= vldP1;
            if (vldP1) begin
                dataP2  <= dataP1 << shiftP1;
                shiftP2 <= shiftP1;
                zeroP2  <= (posP1 == '0);
                idP2    <= idP1;
            end
        end
    end

    assign out_valid = vldP2;
    assign out_data  = dataP2;
    assign out_shift = shiftP2;
    assign out_zero  = zeroP2;
    assign out_id    = idP2;

endmodule

// File: tb/tb_lod_norm_arbiter.sv
// Testbench for lod_norm_arbiter: directed sequences, a vector table and a
// randomized run compared against a transaction-level reference model.
module tb_lod_norm_arbiter;
    localparam int W  = 10;
    localparam int N  = 2;
    localparam int SW = 4;
    localparam int IW = 1;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_shift;
    logic           out_zero;
    logic [IW-1:0]  out_id;

    int checks   = 0;
    int failures = 0;

    lod_norm_arbiter #(.W(W), .N(N), .SW(SW), .IW(IW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shift (out_shift),
        .out_zero  (out_zero),
        .out_id    (out_id)
    );

    always #5 clock = ~clock;

    typedef struct {
        int id;
        int val;
        int expData;
        int expShift;
        int expZero;
    } vec_t;

    typedef struct {
        int val;
        int id;
        int acc;
    } item_t;

    vec_t  vecs[8];
    item_t q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Number of doublings needed to bring the top set bit to bit W-1.
    function automatic int refShift(input int v);
        int s;
        int x;
        if (v == 0) return W;
        s = 0;
        x = v;
        while (x < (1 << (W - 1))) begin
            x = x * 2;
            s++;
        end
        return s;
    endfunction

    function automatic int refNorm(input int v);
        if (v == 0) return 0;
        return (v * (1 << refShift(v))) % (1 << W);
    endfunction

    task automatic chkOut(input string name, input int d, input int s, input int z, input int id);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_data"},  int'(out_data),  d);
        chk({name, "_shift"}, int'(out_shift), s);
        chk({name, "_zero"},  int'(out_zero),  z);
        chk({name, "_id"},    int'(out_id),    id);
    endtask

    initial begin
        int rr;
        int expRR[4];
        int expOutId[4];
        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;

        vecs[0] = '{0, 'h3FF, 'h3FF, 0,  0};
        vecs[1] = '{1, 'h001, 'h200, 9,  0};
        vecs[2] = '{1, 'h015, 'h2A0, 5,  0};
        vecs[3] = '{0, 'h000, 'h000, 10, 1};
        vecs[4] = '{1, 'h100, 'h200, 1,  0};
        vecs[5] = '{0, 'h200, 'h200, 0,  0};
        vecs[6] = '{1, 'h07F, 'h3F8, 3,  0};
        vecs[7] = '{0, 'h2AA, 'h2AA, 0,  0};

        // Reset state
        #12;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data",  int'(out_data),  0);
        chk("rst_shift", int'(out_shift), 0);
        chk("rst_zero",  int'(out_zero),  0);
        chk("rst_id",    int'(out_id),    0);
        chk("rst_ready", int'(req_ready), 0);
        tick();
        reset = 1'b1;

        // Both requesters continuously valid: grants alternate, one result per cycle
        expRR    = '{1, 2, 1, 2};
        expOutId = '{0, 1, 0, 1};
        req_valid = 2'b11;
        req_data  = {10'h00F, 10'h001};
        #1;
        chk("rr_ready0", int'(req_ready), expRR[0]);
        tick();
        chk("rr_fill_valid", int'(out_valid), 0);
        chk("rr_ready1", int'(req_ready), expRR[1]);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_out_valid", int'(out_valid), 1);
            chk("rr_out_id", int'(out_id), expOutId[k]);
            chk("rr_out_data", int'(out_data), (expOutId[k] == 0) ? 'h200 : 'h3C0);
            if (k < 2) chk("rr_ready", int'(req_ready), expRR[k + 2]);
        end
        req_valid = '0;
        tick();
        tick();
        tick();
        chk("rr_drain_valid", int'(out_valid), 0);

        // Vector table: one value at a time, result two edges after presentation
        for (int v = 0; v < 8; v++) begin
            req_valid = '0;
            req_valid[vecs[v].id] = 1'b1;
            req_data[vecs[v].id*W +: W] = W'(vecs[v].val);
            #1;
            chk("vec_grant", int'(req_ready), 1 << vecs[v].id);
            tick();
            req_valid = '0;
            tick();
            chkOut("vec", vecs[v].expData, vecs[v].expShift, vecs[v].expZero, vecs[v].id);
        end
        tick();
        chk("vec_drain_valid", int'(out_valid), 0);

        // Backpressure: both stages full, consumer stalls three cycles
        out_ready = 1'b0;
        req_valid = 2'b01;
        req_data  = {10'h003, 10'h001};
        #1;
        chk("bp_grant0", int'(req_ready), 1);
        tick();
        req_valid = 2'b10;
        #1;
        chk("bp_grant1", int'(req_ready), 2);
        tick();
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", int'(req_ready), 0);
            chkOut("bp_hold", 'h200, 9, 0, 0);
            tick();
        end
        out_ready = 1'b1;
        req_valid = '0;
        #1;
        chkOut("bp_first", 'h200, 9, 0, 0);
        tick();
        chkOut("bp_second", 'h300, 8, 0, 1);
        tick();
        chk("bp_empty", int'(out_valid), 0);

        // Reset while both stages hold results, pointer left at 1
        out_ready = 1'b0;
        req_valid = 2'b10;
        req_data  = {10'h0F0, 10'h00F};
        tick();
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        chk("rf_full_valid", int'(out_valid), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rf_valid", int'(out_valid), 0);
        chk("rf_data",  int'(out_data),  0);
        chk("rf_shift", int'(out_shift), 0);
        chk("rf_id",    int'(out_id),    0);
        tick();
        reset = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("rf_first_grant", int'(req_ready), 1);
        tick();
        chk("rf_no_replay", int'(out_valid), 0);

        // Randomized traffic against the transaction model
        req_valid = '0;
        out_ready = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        rr = 0;
        q.delete();
        for (int c = 0; c < 600; c++) begin
            logic expValid;
            logic canAccept;
            int   g;
            int   expReady;
            expValid = (q.size() > 0) && (c >= q[0].acc + 1);
            chk("rnd_valid", int'(out_valid), int'(expValid));
            if (expValid) begin
                chk("rnd_data",  int'(out_data),  refNorm(q[0].val));
                chk("rnd_shift", int'(out_shift), refShift(q[0].val));
                chk("rnd_zero",  int'(out_zero),  (q[0].val == 0) ? 1 : 0);
                chk("rnd_id",    int'(out_id),    q[0].id);
            end
            req_valid = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                req_data[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            canAccept = (q.size() < 2) || (expValid && out_ready);
            g = -1;
            if (canAccept) begin
                for (int off = 0; off < N; off++) begin
                    if (g < 0 && req_valid[(rr + off) % N]) g = (rr + off) % N;
                end
            end
            expReady = (g >= 0) ? (1 << g) : 0;
            chk("rnd_ready", int'(req_ready), expReady);
            tick();
            if (expValid && out_ready) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back('{int'(req_data[g*W +: W]), g, c + 1});
                rr = (g + 1) % N;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
